// File: rtl/ysyx22041405_mem_arb.sv
// Shares the single memory port between IFU and LSU. Each transaction runs
// IDLE (arbitrate + grant) -> REQ (hold mem_req) -> WAIT (await mem_rvalid).
module ysyx22041405_mem_arb #(
  parameter int WIDTH       = 32,
  parameter int MAX_LSU_RUN = 4   // legal range 1..15 (run_cnt is 4 bits)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ifu_req,
  input  logic [WIDTH-1:0]   ifu_addr,
  output logic               ifu_gnt,
  output logic               ifu_rvalid,
  output logic [WIDTH-1:0]   ifu_rdata,
  input  logic               lsu_req,
  input  logic               lsu_we,
  input  logic [WIDTH-1:0]   lsu_addr,
  input  logic [WIDTH-1:0]   lsu_wdata,
  input  logic [WIDTH/8-1:0] lsu_wstrb,
  output logic               lsu_gnt,
  output logic               lsu_rvalid,
  output logic [WIDTH-1:0]   lsu_rdata,
  output logic               mem_req,
  output logic               mem_we,
  output logic [WIDTH-1:0]   mem_addr,
  output logic [WIDTH-1:0]   mem_wdata,
  output logic [WIDTH/8-1:0] mem_wstrb,
  input  logic               mem_ready,
  input  logic               mem_rvalid,
  input  logic [WIDTH-1:0]   mem_rdata
);

  localparam int         SW      = WIDTH / 8;
  localparam logic [3:0] RUN_MAX = 4'(MAX_LSU_RUN);

  // Handshakes: a client holds req until its one-cycle gnt pulse, after which
  // the transaction is owned here; mem_req is held until mem_ready is seen,
  // and the reply is the single mem_rvalid cycle that follows in WAIT.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic              owner_lsu;
  logic [3:0]        run_cnt;
  logic              we_q;
  logic [WIDTH-1:0]  addr_q;
  logic [WIDTH-1:0]  wdata_q;
  logic [SW-1:0]     wstrb_q;

  logic              ifu_starved;
  logic              pick_lsu;
  logic              pick_ifu;

  // LSU has priority unless the IFU has already watched RUN_MAX LSU grants.
  assign ifu_starved = ifu_req && (run_cnt == RUN_MAX);
  assign pick_lsu    = lsu_req && !ifu_starved;
  assign pick_ifu    = ifu_req && !pick_lsu;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner_lsu <= 1'b0;
      run_cnt   <= 4'd0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
    end else if (state == S_IDLE) begin
      if (pick_lsu) begin
        owner_lsu <= 1'b1;
        we_q      <= lsu_we;
        addr_q    <= lsu_addr;
        wdata_q   <= lsu_wdata;
        wstrb_q   <= lsu_we ? lsu_wstrb : '0;
      end else if (pick_ifu) begin
        owner_lsu <= 1'b0;
        we_q      <= 1'b0;
        addr_q    <= ifu_addr;
        wdata_q   <= '0;
        wstrb_q   <= '0;
      end
      if (pick_lsu && ifu_req) begin
        run_cnt <= (run_cnt == RUN_MAX) ? run_cnt : run_cnt + 4'd1;
      end else begin
        run_cnt <= 4'd0;
      end
    end
  end

  always_comb begin
    state_nxt  = state;
    ifu_gnt    = 1'b0;
    lsu_gnt    = 1'b0;
    ifu_rvalid = 1'b0;
    lsu_rvalid = 1'b0;
    mem_req    = 1'b0;
    case (state)
      S_IDLE: begin
        lsu_gnt = pick_lsu;
        ifu_gnt = pick_ifu;
        if (pick_lsu || pick_ifu) begin
          state_nxt = S_REQ;
        end
      end
      S_REQ: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        if (mem_rvalid) begin
          ifu_rvalid = !owner_lsu;
          lsu_rvalid = owner_lsu;
          state_nxt  = S_IDLE;
        end
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // Payload is only presented while requesting, so the port idles at zero.
  assign mem_we    = mem_req && we_q;
  assign mem_addr  = mem_req ? addr_q  : '0;
  assign mem_wdata = mem_req ? wdata_q : '0;
  assign mem_wstrb = mem_req ? wstrb_q : '0;

  assign ifu_rdata = mem_rdata;
  assign lsu_rdata = mem_rdata;

endmodule

// File: tb/tb_ysyx22041405_mem_arb.sv
// Bench for ysyx22041405_mem_arb: directed phases plus random IFU/LSU traffic
// against a transaction-level arbiter model and a word-addressed memory.
module tb_ysyx22041405_mem_arb;

  localparam int W       = 32;
  localparam int MAX_RUN = 4;

  logic          clk;
  logic          rst_n;
  logic          ifu_req;
  logic [W-1:0]  ifu_addr;
  logic          ifu_gnt;
  logic          ifu_rvalid;
  logic [W-1:0]  ifu_rdata;
  logic          lsu_req;
  logic          lsu_we;
  logic [W-1:0]  lsu_addr;
  logic [W-1:0]  lsu_wdata;
  logic [3:0]    lsu_wstrb;
  logic          lsu_gnt;
  logic          lsu_rvalid;
  logic [W-1:0]  lsu_rdata;
  logic          mem_req;
  logic          mem_we;
  logic [W-1:0]  mem_addr;
  logic [W-1:0]  mem_wdata;
  logic [3:0]    mem_wstrb;
  logic          mem_ready;
  logic          mem_rvalid;
  logic [W-1:0]  mem_rdata;

  ysyx22041405_mem_arb #(.WIDTH(W), .MAX_LSU_RUN(MAX_RUN)) dut (
    .clk(clk), .rst_n(rst_n),
    .ifu_req(ifu_req), .ifu_addr(ifu_addr), .ifu_gnt(ifu_gnt),
    .ifu_rvalid(ifu_rvalid), .ifu_rdata(ifu_rdata),
    .lsu_req(lsu_req), .lsu_we(lsu_we), .lsu_addr(lsu_addr),
    .lsu_wdata(lsu_wdata), .lsu_wstrb(lsu_wstrb), .lsu_gnt(lsu_gnt),
    .lsu_rvalid(lsu_rvalid), .lsu_rdata(lsu_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_ready(mem_ready),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish within time limit");
    $fatal(1, "bench timeout");
  end

  // ---------------- scoreboard state ----------------
  typedef struct packed {
    logic         lsu;
    logic         we;
    logic [W-1:0] addr;
    logic [W-1:0] wdata;
    logic [3:0]   wstrb;
  } req_t;

  typedef struct packed {
    logic         lsu;
    logic         we;
    logic [W-1:0] data;
  } rsp_t;

  req_t          exp_req_q[$];
  rsp_t          exp_rsp_q[$];
  logic          glog[$];
  logic [W-1:0]  mem_arr[logic [29:0]];
  bit            busy;
  bit            req_due;
  int            streak;
  bit            auto_stop;
  int            n_pass;
  int            n_total;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [W-1:0] mem_read(input logic [W-1:0] a);
    if (mem_arr.exists(a[31:2])) return mem_arr[a[31:2]];
    return ~a;
  endfunction

  function automatic void mem_write(input logic [W-1:0] a, input logic [W-1:0] d,
                                    input logic [3:0] s);
    logic [W-1:0] w;
    w = mem_read(a);
    for (int b = 0; b < 4; b++) if (s[b]) w[8*b +: 8] = d[8*b +: 8];
    mem_arr[a[31:2]] = w;
  endfunction

  // ---------------- monitor + reference model ----------------
  // Model: one transaction at a time; LSU wins unless the IFU has been
  // passed over MAX_RUN times in a row while waiting.
  always @(negedge clk) begin
    bit   exp_rv;
    bit   popped;
    bit   e_l;
    bit   e_i;
    rsp_t s;
    req_t r;
    if (!rst_n) begin
      exp_req_q.delete();
      exp_rsp_q.delete();
      busy    = 0;
      req_due = 0;
      streak  = 0;
      check("reset_outputs",
            {mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
             ifu_gnt, lsu_gnt, ifu_rvalid, lsu_rvalid}, '0);
    end else begin
      popped = 0;
      exp_rv = mem_rvalid && (exp_rsp_q.size() != 0);
      s      = exp_rv ? exp_rsp_q[0] : '0;
      if (mem_rvalid || ifu_rvalid || lsu_rvalid) begin
        check("rvalid_route", {ifu_rvalid, lsu_rvalid},
              {exp_rv && !s.lsu, exp_rv && s.lsu});
        if (exp_rv) begin
          void'(exp_rsp_q.pop_front());
          if (!s.we) check(s.lsu ? "lsu_rdata" : "ifu_rdata",
                           s.lsu ? lsu_rdata : ifu_rdata, s.data);
          popped = 1;
        end
      end

      if (req_due) begin
        check("gnt_to_mem_req_latency", mem_req, 1'b1);
        req_due = 0;
      end

      if (mem_req) begin
        if (exp_req_q.size() == 0) begin
          check("mem_req_unexpected", mem_req, 1'b0);
        end else begin
          r = exp_req_q[0];
          check("mem_payload",
                {mem_we, mem_addr, mem_wstrb, mem_we ? mem_wdata : 32'h0},
                {r.we, r.addr, r.wstrb, r.we ? r.wdata : 32'h0});
          if (mem_ready) begin
            void'(exp_req_q.pop_front());
            if (r.we) mem_write(r.addr, r.wdata, r.wstrb);
            exp_rsp_q.push_back('{lsu: r.lsu, we: r.we,
                                  data: r.we ? 32'h0 : mem_read(r.addr)});
          end
        end
      end

      if (!busy) begin
        e_l = lsu_req && !(ifu_req && streak == MAX_RUN);
        e_i = !e_l && ifu_req;
        if (ifu_req || lsu_req || ifu_gnt || lsu_gnt)
          check("grant", {ifu_gnt, lsu_gnt}, {e_i, e_l});
        if (e_l)
          exp_req_q.push_back('{lsu: 1'b1, we: lsu_we, addr: lsu_addr,
                                wdata: lsu_wdata, wstrb: lsu_we ? lsu_wstrb : 4'h0});
        if (e_i)
          exp_req_q.push_back('{lsu: 1'b0, we: 1'b0, addr: ifu_addr,
                                wdata: 32'h0, wstrb: 4'h0});
        if (e_l || e_i) begin
          busy    = 1;
          req_due = 1;
        end
        if (e_l && ifu_req) streak = (streak == MAX_RUN) ? streak : streak + 1;
        else streak = 0;
      end else if (ifu_req || lsu_req || ifu_gnt || lsu_gnt) begin
        check("no_grant_while_busy", {ifu_gnt, lsu_gnt}, 2'b00);
      end
      if (ifu_gnt || lsu_gnt) glog.push_back(lsu_gnt);
      if (popped) busy = 0;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic ifu_txn(input logic [W-1:0] a);
    bit got;
    @(posedge clk); #1;
    ifu_req  = 1'b1;
    ifu_addr = a;
    got = 0;
    for (int k = 0; k < 2000; k++) begin
      @(negedge clk);
      if (ifu_gnt) begin got = 1; break; end
    end
    if (!got) check("ifu_gnt_timeout", 1'b0, 1'b1);
    @(posedge clk); #1;
    ifu_req = 1'b0;
  endtask

  task automatic lsu_txn(input logic we, input logic [W-1:0] a,
                         input logic [W-1:0] d, input logic [3:0] s);
    bit got;
    @(posedge clk); #1;
    lsu_req   = 1'b1;
    lsu_we    = we;
    lsu_addr  = a;
    lsu_wdata = d;
    lsu_wstrb = s;
    got = 0;
    for (int k = 0; k < 2000; k++) begin
      @(negedge clk);
      if (lsu_gnt) begin got = 1; break; end
    end
    if (!got) check("lsu_gnt_timeout", 1'b0, 1'b1);
    @(posedge clk); #1;
    lsu_req = 1'b0;
  endtask

  function automatic logic [W-1:0] rand_addr();
    return 32'h8000_0000 | (32'($urandom_range(0, 15)) << 2);
  endfunction

  task automatic ifu_run(input int n, input int gap_max);
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(0, gap_max)) @(posedge clk);
      ifu_txn(rand_addr());
    end
  endtask

  task automatic lsu_run(input int n, input int gap_max);
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(0, gap_max)) @(posedge clk);
      lsu_txn(1'($urandom_range(0, 1)), rand_addr(), $urandom, 4'($urandom_range(0, 15)));
    end
  endtask

  // Random-latency memory; also throws stray mem_rvalid pulses outside WAIT.
  task automatic mem_auto();
    int           phase;
    logic         acc_we;
    logic [W-1:0] acc_addr;
    phase    = 0;
    acc_we   = 1'b0;
    acc_addr = '0;
    while (!auto_stop) begin
      @(posedge clk); #1;
      mem_ready  = 1'b0;
      mem_rvalid = 1'b0;
      if (phase == 0) begin
        if (mem_req) begin
          if ($urandom_range(0, 2) == 0) begin
            mem_ready = 1'b1;
            acc_we    = mem_we;
            acc_addr  = mem_addr;
            phase     = 1;
          end else if ($urandom_range(0, 4) == 0) begin
            mem_rvalid = 1'b1;
            mem_rdata  = $urandom;
          end
        end else if ($urandom_range(0, 7) == 0) begin
          mem_rvalid = 1'b1;
          mem_rdata  = $urandom;
        end
      end else if ($urandom_range(0, 1) == 0) begin
        mem_rvalid = 1'b1;
        mem_rdata  = acc_we ? $urandom : mem_read(acc_addr);
        phase      = 0;
      end
    end
    mem_ready  = 1'b0;
    mem_rvalid = 1'b0;
  endtask

  task automatic wait_idle();
    bit done;
    done = 0;
    for (int k = 0; k < 500; k++) begin
      @(negedge clk);
      if (!busy && exp_req_q.size() == 0 && exp_rsp_q.size() == 0) begin
        done = 1;
        break;
      end
    end
    if (!done) check("drain_timeout", 1'b0, 1'b1);
  endtask

  task automatic run_traffic(input int n_ifu, input int n_lsu, input int gap_max);
    auto_stop = 0;
    fork
      begin
        fork
          ifu_run(n_ifu, gap_max);
          lsu_run(n_lsu, gap_max);
        join
        wait_idle();
        auto_stop = 1;
      end
      mem_auto();
    join
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int           req_cycles;
    logic [9:0]   got_order;
    logic [9:0]   exp_order;
    n_pass = 0; n_total = 0;
    rst_n = 1'b0;
    ifu_req = 1'b0; ifu_addr = '0;
    lsu_req = 1'b0; lsu_we = 1'b0; lsu_addr = '0; lsu_wdata = '0; lsu_wstrb = '0;
    mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    auto_stop = 1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Reset while requesting: abandon, and a late reply must not surface.
    ifu_txn(32'h8000_0100);
    #1 check("req_before_reset", mem_req, 1'b1);
    #1 rst_n = 1'b0;
    #1 check("reset_async_mem_req", {mem_req, mem_addr}, '0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1 mem_rvalid = 1'b1; mem_rdata = 32'h1234_5678;
    @(negedge clk);
    check("late_rvalid_ignored", {ifu_rvalid, lsu_rvalid}, 2'b00);
    @(posedge clk); #1 mem_rvalid = 1'b0;

    // IFU fetch with the minimum 3-cycle latency.
    mem_arr[30'h2000_0000] = 32'h0000_0413;
    @(posedge clk); #1 ifu_req = 1'b1; ifu_addr = 32'h8000_0000;
    @(negedge clk);
    check("ifu_gnt_T", {ifu_gnt, lsu_gnt}, 2'b10);
    @(posedge clk); #1 ifu_req = 1'b0; mem_ready = 1'b1;
    @(negedge clk);
    check("ifu_mem_T1", {mem_req, mem_we, mem_addr, mem_wstrb}, {2'b10, 32'h8000_0000, 4'h0});
    @(posedge clk); #1 mem_ready = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h0000_0413;
    @(negedge clk);
    check("ifu_rvalid_T2", {ifu_rvalid, lsu_rvalid, ifu_rdata}, {2'b10, 32'h0000_0413});
    @(posedge clk); #1 mem_rvalid = 1'b0;

    // LSU store under backpressure, with a stray mem_rvalid in REQ.
    @(posedge clk); #1;
    lsu_req = 1'b1; lsu_we = 1'b1; lsu_addr = 32'h8000_1004;
    lsu_wdata = 32'hDEAD_BEEF; lsu_wstrb = 4'b0011;
    req_cycles = 0;
    @(negedge clk);
    check("store_gnt", {ifu_gnt, lsu_gnt}, 2'b01);
    @(posedge clk); #1 lsu_req = 1'b0;
    @(negedge clk); if (mem_req) req_cycles++;
    @(posedge clk); #1 mem_rvalid = 1'b1; mem_rdata = 32'hBAD0_BAD0;
    @(negedge clk); if (mem_req) req_cycles++;
    @(posedge clk); #1 mem_rvalid = 1'b0;
    @(negedge clk); if (mem_req) req_cycles++;
    @(posedge clk); #1 mem_ready = 1'b1;
    @(negedge clk); if (mem_req) req_cycles++;
    check("store_req_cycles", 32'(req_cycles), 32'd4);
    @(posedge clk); #1 mem_ready = 1'b0;
    @(negedge clk);
    check("store_wait_no_req", {mem_req, lsu_rvalid}, 2'b00);
    @(posedge clk); #1 mem_rvalid = 1'b1; mem_rdata = 32'h0;
    @(negedge clk);
    check("store_ack", {ifu_rvalid, lsu_rvalid}, 2'b01);
    @(posedge clk); #1 mem_rvalid = 1'b0; lsu_we = 1'b0;

    // Both saturating the port: expect L L L L I L L L L I.
    glog.delete();
    run_traffic(2, 8, 0);
    got_order = '0;
    exp_order = '0;
    for (int i = 0; i < 10; i++) begin
      if (i < glog.size()) got_order[i] = glog[i];
      exp_order[i] = (i % 5) != 4;
    end
    check("grant_count", 32'(glog.size()), 32'd10);
    check("grant_order", got_order, exp_order);

    // Random mixed traffic.
    run_traffic(60, 80, 4);
    run_traffic(40, 40, 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
